// File: rtl/stopwatch_counter_pkg.sv
// Shared constants for the stopwatch core: FSM encoding, digit limits and widths,
// plus the single-digit BCD step used by both the digit cells and the lap display path.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int TENTH_MAX  = 9;
    localparam int SEC_LO_MAX = 9;
    localparam int SEC_HI_MAX = 5;
    localparam int MIN_LO_MAX = 9;
    localparam int MIN_HI_MAX = 5;

    localparam int TENTH_W  = 4;
    localparam int SEC_LO_W = 4;
    localparam int SEC_HI_W = 3;
    localparam int MIN_LO_W = 4;
    localparam int MIN_HI_W = 3;

    // Next value of one digit; clr dominates, otherwise wrap at max when incremented.
    function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic [3:0] max,
                                            input logic inc, input logic clr);
        logic [3:0] r;
        r = v;
        if (clr) begin
            r = 4'd0;
        end else if (inc) begin
            r = (v == max) ? 4'd0 : v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit with a configurable maximum; carry is combinational so a chain of
// these ripples within a single clock.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [3:0] next_ext;

    assign carry    = inc & (value == MAX_V);
    assign next_ext = bcd_step(4'(value), 4'(MAX), inc, clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= next_ext[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: MM:SS.t BCD count driven by the 100 ms divider tick,
// with IDLE/RUN/PAUSE control. Optional lap display freeze under STOPWATCH_LAP_HOLD_EN.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] d_tenth,
    output logic [3:0] d_sec_lo,
    output logic [2:0] d_sec_hi,
    output logic [3:0] d_min_lo,
    output logic [2:0] d_min_hi,
    output logic       running,
    output logic       overflow,
    output logic       lap_active
);

    logic   tick_d;
    logic   tick_rise;
    state_t state;
    state_t state_next;
    logic   count_inc;

    logic [TENTH_W-1:0]  tenth;
    logic [SEC_LO_W-1:0] sec_lo;
    logic [SEC_HI_W-1:0] sec_hi;
    logic [MIN_LO_W-1:0] min_lo;
    logic [MIN_HI_W-1:0] min_hi;
    logic c_tenth, c_sec_lo, c_sec_hi, c_min_lo, c_min_hi;

    assign tick_rise = tick_in & ~tick_d;
    // A tick is counted only while already in RUN; clear discards it.
    assign count_inc = (state == RUN) & tick_rise & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_in;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
        end
    end

    bcd_digit #(.WIDTH(TENTH_W), .MAX(TENTH_MAX)) u_tenth (
        .clk(clk), .rst_n(rst_n), .inc(count_inc), .clr(clear),
        .value(tenth), .carry(c_tenth)
    );

    bcd_digit #(.WIDTH(SEC_LO_W), .MAX(SEC_LO_MAX)) u_sec_lo (
        .clk(clk), .rst_n(rst_n), .inc(c_tenth), .clr(clear),
        .value(sec_lo), .carry(c_sec_lo)
    );

    bcd_digit #(.WIDTH(SEC_HI_W), .MAX(SEC_HI_MAX)) u_sec_hi (
        .clk(clk), .rst_n(rst_n), .inc(c_sec_lo), .clr(clear),
        .value(sec_hi), .carry(c_sec_hi)
    );

    bcd_digit #(.WIDTH(MIN_LO_W), .MAX(MIN_LO_MAX)) u_min_lo (
        .clk(clk), .rst_n(rst_n), .inc(c_sec_hi), .clr(clear),
        .value(min_lo), .carry(c_min_lo)
    );

    bcd_digit #(.WIDTH(MIN_HI_W), .MAX(MIN_HI_MAX)) u_min_hi (
        .clk(clk), .rst_n(rst_n), .inc(c_min_lo), .clr(clear),
        .value(min_hi), .carry(c_min_hi)
    );

    // The top digit's carry coincides with the edge on which the count becomes 00:00.0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (c_min_hi) begin
            overflow <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [3:0] tenth_nx, sec_lo_nx, sec_hi_nx, min_lo_nx, min_hi_nx;
    logic       lap_q;

    // Tracking uses the next live value so the display is not a cycle behind the count.
    assign tenth_nx  = bcd_step(4'(tenth),  4'(TENTH_MAX),  count_inc, clear);
    assign sec_lo_nx = bcd_step(4'(sec_lo), 4'(SEC_LO_MAX), c_tenth,   clear);
    assign sec_hi_nx = bcd_step(4'(sec_hi), 4'(SEC_HI_MAX), c_sec_lo,  clear);
    assign min_lo_nx = bcd_step(4'(min_lo), 4'(MIN_LO_MAX), c_sec_hi,  clear);
    assign min_hi_nx = bcd_step(4'(min_hi), 4'(MIN_HI_MAX), c_min_lo,  clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_tenth  <= '0;
            d_sec_lo <= '0;
            d_sec_hi <= '0;
            d_min_lo <= '0;
            d_min_hi <= '0;
            lap_q    <= 1'b0;
        end else if (clear) begin
            d_tenth  <= '0;
            d_sec_lo <= '0;
            d_sec_hi <= '0;
            d_min_lo <= '0;
            d_min_hi <= '0;
            lap_q    <= 1'b0;
        end else if (lap && !lap_q && (state != IDLE)) begin
            d_tenth  <= tenth;
            d_sec_lo <= sec_lo;
            d_sec_hi <= sec_hi;
            d_min_lo <= min_lo;
            d_min_hi <= min_hi;
            lap_q    <= 1'b1;
        end else if (lap && lap_q) begin
            lap_q    <= 1'b0;
        end else if (!lap_q) begin
            d_tenth  <= tenth_nx;
            d_sec_lo <= sec_lo_nx;
            d_sec_hi <= sec_hi_nx[2:0];
            d_min_lo <= min_lo_nx;
            d_min_hi <= min_hi_nx[2:0];
        end
    end

    assign lap_active = lap_q;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign d_tenth    = tenth;
    assign d_sec_lo   = sec_lo;
    assign d_sec_hi   = sec_hi;
    assign d_min_lo   = min_lo;
    assign d_min_hi   = min_hi;
    assign lap_active = 1'b0;
`endif

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch: consumes the 100 ms square wave produced by the clock divider and advances a BCD count of minutes, seconds and tenths (MM:SS.t, max 59:59.9). It runs from the system clock and sits between the divider and the display multiplexer. A start/stop/pause control FSM and an optional lap-hold display freeze are included.

## Interface
- No parameters; digit limits are fixed constants (see Structure).
- `clk` input 1: system clock, same clock that drives the divider.
- `rst_n` input 1: reset, asynchronous, active-low.
- `tick_in` input 1: divider output, a 100 ms period square wave synchronous to `clk`.
- `start_stop` input 1: one-cycle pulse (debounced upstream) that toggles run/pause.
- `clear` input 1: one-cycle pulse that zeroes the count and returns to IDLE.
- `lap` input 1: one-cycle pulse that toggles display freeze (LAP_HOLD_EN only).
- `d_tenth` output 4: displayed tenths, 0–9.
- `d_sec_lo` output 4: displayed seconds units, 0–9.
- `d_sec_hi` output 3: displayed seconds tens, 0–5.
- `d_min_lo` output 4: displayed minutes units, 0–9.
- `d_min_hi` output 3: displayed minutes tens, 0–5.
- `running` output 1: high in RUN.
- `overflow` output 1: sticky; set on wrap from 59:59.9, cleared only by `clear` or reset.
- `lap_active` output 1: display frozen.

## Operation
- Edge detect: register `tick_in` into `tick_d`. `tick_rise = tick_in & ~tick_d`, which gives one pulse per 100 ms.
- FSM states: IDLE, RUN, PAUSE. Reset and `clear` both go to IDLE.
  - IDLE: `start_stop` goes to RUN.
  - RUN: `start_stop` goes to PAUSE.
  - PAUSE: `start_stop` goes to RUN.
- Counting happens only in RUN, on `tick_rise`, as a cascaded BCD chain.
  - Tenths goes 9 to 0 and carries into seconds units.
  - Seconds units goes 9 to 0 and carries into seconds tens.
  - Seconds tens goes 5 to 0 and carries into minutes units.
  - Minutes units goes 9 to 0 and carries into minutes tens.
  - Minutes tens goes 5 to 0 and sets `overflow`.
  - Counting continues after overflow.
- Each digit carries only when it wraps and its input increment is asserted. Digits never hold an out-of-range value.
- Priority in one cycle: `clear` > `start_stop` > tick.
  - `clear` with a tick: the count becomes 0 and the tick is discarded.
  - `start_stop` with a tick while in RUN: the tick is counted, then the FSM enters PAUSE.
  - `start_stop` with a tick while in IDLE or PAUSE: the FSM enters RUN and the tick is not counted.
- `clear` zeroes the live count, the display latch, `overflow` and `lap_active`.
- Reset during operation behaves identically to `clear`, except that it is asynchronous.

## Timing
- Reset values:
  - all digits 0;
  - `running`, `overflow` and `lap_active` 0;
  - `tick_d` 0;
  - state IDLE.
- All outputs are registered.
- Latency from tick to digits: `tick_in` rises after clock edge N, the digits update at edge N+1, and they are visible after N+1.
- Latency from control to state: a `start_stop` sampled at edge N makes `running` change after edge N.
- `overflow` rises on the same edge at which the digits become 00:00.0.
- Holding `tick_in` high produces exactly one count. A tick that arrives while not in RUN is dropped, not queued.

## Configuration
- Macro `STOPWATCH_LAP_HOLD_EN`.
- Defined:
  - A `lap` pulse in RUN or PAUSE with `lap_active`=0 copies the live count into the display latch and sets `lap_active`.
  - A second `lap` pulse clears `lap_active`, and the display tracks the live count again on the next edge.
  - The live count keeps advancing while the display is frozen.
  - `lap` in IDLE is ignored.
  - `clear` wins over `lap`.
- Undefined:
  - `lap` is ignored.
  - `lap_active` is tied to 0.
  - Display outputs are the live count registers, with no latch flops.

## Structure
- Package `stopwatch_pkg` holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2;
  - digit maxima: TENTH_MAX=9, SEC_LO_MAX=9, SEC_HI_MAX=5, MIN_LO_MAX=9, MIN_HI_MAX=5;
  - digit widths.
- Sub-module `bcd_digit`: one digit with configurable maximum, inputs `inc` and `clr`, outputs `value` and `carry`.
  - `carry = inc & (value == MAX)`.
  - Five instances are chained.

## Test plan
- Reset, then `start_stop`, then 10 ticks → display reads 00:01.0 and `running`=1.
- Count loaded at 00:59.9 in RUN, then 1 tick → 01:00.0 with no overflow.
- 59:59.9 then 1 tick → 00:00.0 and `overflow`=1. Another tick → 00:00.1 with `overflow` still 1. `clear` → all 0 and `overflow`=0.
- RUN at 00:00.5, `start_stop` and a tick in the same cycle → 00:00.6 and PAUSE. Three further ticks → still 00:00.6. `start_stop` then 1 tick → 00:00.7.
- `clear` and a tick in the same cycle in RUN → 00:00.0 and IDLE. `tick_in` held high 50 cycles after restart → exactly +1.
- STOPWATCH_LAP_HOLD_EN: RUN at 00:02.3, `lap`, then 7 ticks → display 00:02.3 and `lap_active`=1. Second `lap` → display 00:03.0 one edge later.
